l_commit_stage: RTL and testbench
=================================

Name: l_commit_stage

Overview:
- Writeback/commit stage directly downstream of the L-series ALU complex.
- Registers the complex's results and write strobes with a valid/ready handshake, then commits them:
  - register-file write
  - SP/PC/RA architectural registers
  - single-word memory store via req/ack handshake
- Owns the architectural PC, SP and RA that feed back into the complex's pcIn/spIn/raIn.
- Issues a one-cycle retire pulse per instruction.

Parameters:
- DATA_W, 16, datapath width.
- RF_ADDR_W, 3, register-file address width.
- RESET_PC, 16'h0000, PC value after reset.
- RESET_SP, 16'hFFFF, SP value after reset.
- RESET_RA, 16'h0000, RA value after reset.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU complex result valid.
- in_ready  out  1  stage can accept a result.
- instruction  in  16  instruction being committed; rd = instruction[2:0].
- alu_out  in  DATA_W  register-file write data (complex "out").
- sp_in, pc_in, ra_in  in  DATA_W each  candidate SP/PC/RA values (complex spOut/pcOut/raOut).
- mem_data_in, mem_addr_in  in  DATA_W each  store data/address.
- register_write, sp_write, pc_write, ra_write, memory_write  in  1 each  commit strobes.
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_waddr  out  RF_ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- mem_req  out  1  store request.
- mem_addr  out  DATA_W  store address.
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  store accepted.
- sp, pc, ra  out  DATA_W each  architectural registers.
- retire  out  1  one-cycle pulse per committed instruction.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE; in_ready = 1.
  - rf_we = mem_req = retire = 0; rf_waddr/rf_wdata/mem_addr/mem_wdata = 0.
  - pc = RESET_PC, sp = RESET_SP, ra = RESET_RA.
- States:
  - IDLE: in_ready = 1. When in_valid && in_ready, capture all inputs into holding registers and go to COMMIT.
  - COMMIT:
    - memory_write = 0: retire this cycle and return to IDLE.
    - memory_write = 1: assert mem_req with held address/data. If mem_ack is high in this same cycle, retire now and return to IDLE; otherwise go to MEM_WAIT.
  - MEM_WAIT: hold mem_req, mem_addr and mem_wdata stable until the cycle mem_ack = 1; retire in that cycle; return to IDLE.
- Retire cycle, all updates take effect together:
  - rf_we = register_write, rf_waddr = rd, rf_wdata = held alu_out.
  - sp <= sp_write ? held sp_in : sp.
  - ra <= ra_write ? held ra_in : ra.
  - pc <= pc_write ? held pc_in : pc + 1, 16-bit wrap (16'hFFFF -> 16'h0000).
  - retire = 1; mem_req deasserts on the following cycle.
- Latency and throughput:
  - Capture to retire is 1 cycle with no store, 1+N cycles with a store (N = ack wait, N ≥ 0 extra).
  - in_ready is low from capture until the cycle after retire.
  - Peak throughput is one instruction per 2 cycles.
- mem_ack while not in COMMIT/MEM_WAIT (mem_req low) is ignored.
- Any strobe combination is legal. All strobes 0 → PC increments only; retire still pulses.
- Reset during MEM_WAIT or COMMIT:
  - mem_req drops on the next edge; the pending instruction is discarded without retiring.
  - Architectural registers return to reset values.
- in_valid while in_ready = 0 is not captured. Upstream holds its data until accepted.

Optional Feature:
- Macro: L_COMMIT_PERF_EN.
- Defined:
  - Adds outputs retire_count (32) and stall_count (32), both reset to 0.
  - retire_count increments on each retire.
  - stall_count increments each MEM_WAIT cycle.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: neither port nor its counter logic exists. All other behaviour is identical.

Decomposition:
- Shared package l_core_pkg:
  - DATA_W default, state encoding enum (IDLE, COMMIT, MEM_WAIT).
  - rd field position constants (RD_LSB = 0, RD_MSB = 2).
  - RESET_PC/RESET_SP defaults.
- One natural sub-module, l_commit_store_port: the mem_req/mem_ack holding logic and its ack-in-same-cycle rule.

Test Plan:
- ADD-type retire: in_valid with register_write = 1, rd = 3, alu_out = 16'h1234, pc = 16'h0010 → two cycles later rf_we pulse, rf_waddr = 3, rf_wdata = 16'h1234, pc = 16'h0011, retire = 1.
- Branch taken: pc_write = 1, pc_in = 16'h0200 → pc = 16'h0200 at retire. PC wrap: pc = 16'hFFFF with no pc_write → pc = 16'h0000.
- Store with 3-cycle ack delay: memory_write = 1, mem_addr_in = 16'h8000, data = 16'hBEEF → mem_req held with stable addr/data for 4 cycles; retire in the ack cycle; in_ready low throughout.
- Same-cycle ack: mem_ack tied high → store retires in COMMIT; no MEM_WAIT visit; mem_req high exactly 1 cycle.
- JUMP-style commit: pc_write, ra_write and memory_write all set → pc/ra/rf update only in the ack cycle. Reset asserted mid-MEM_WAIT → no retire; pc = RESET_PC, sp = 16'hFFFF, mem_req = 0 next cycle.
- With L_COMMIT_PERF_EN: 5 instructions including one store acked after 2 wait cycles → retire_count = 5, stall_count = 2.

Source files
------------

// File: rtl/l_core_pkg.sv
// Shared L-series core constants: default widths, reset values, rd field
// position and the commit-stage state encoding.
package l_core_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_RF_ADDR_W = 3;

  localparam int unsigned RD_LSB = 0;
  localparam int unsigned RD_MSB = 2;

  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [15:0] DEF_RESET_SP = 16'hFFFF;
  localparam logic [15:0] DEF_RESET_RA = 16'h0000;

  // Encodings stay fixed so legacy state dumps remain readable.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COMMIT   = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    COMMIT   = ST_COMMIT,
    MEM_WAIT = ST_MEM_WAIT
  } commit_state_t;

endpackage

// File: rtl/l_commit_stage_if.sv
// Result bus from the ALU complex into the commit stage (valid/ready plus
// payload and commit strobes).
interface l_commit_stage_if #(
  parameter int unsigned DATA_W = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instruction;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] sp_in;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] ra_in;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_addr_in;
  logic              register_write;
  logic              sp_write;
  logic              pc_write;
  logic              ra_write;
  logic              memory_write;

  modport master (
    output in_valid, instruction, alu_out, sp_in, pc_in, ra_in,
           mem_data_in, mem_addr_in, register_write, sp_write, pc_write,
           ra_write, memory_write,
    input  in_ready
  );

  modport slave (
    input  in_valid, instruction, alu_out, sp_in, pc_in, ra_in,
           mem_data_in, mem_addr_in, register_write, sp_write, pc_write,
           ra_write, memory_write,
    output in_ready
  );

endinterface

// File: rtl/l_commit_store_port.sv
// Single-word store port: holds mem_req/addr/data from start until mem_ack,
// with done raised combinationally in the ack cycle.
module l_commit_store_port #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] store_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done
);

  // Ack only counts while a request is outstanding; stray acks are ignored.
  assign done = mem_req && mem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_addr  <= store_addr;
      mem_wdata <= store_data;
    end else if (done) begin
      mem_req   <= 1'b0;
    end
  end

endmodule

// File: rtl/l_commit_stage.sv
// Writeback/commit stage for the L-series ALU complex; owns PC/SP/RA.
// Optional perf counters (retire_count, stall_count) under L_COMMIT_PERF_EN.
module l_commit_stage
  import l_core_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter int unsigned       RF_ADDR_W = DEF_RF_ADDR_W,
  parameter logic [DATA_W-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [DATA_W-1:0] RESET_SP  = DEF_RESET_SP,
  parameter logic [DATA_W-1:0] RESET_RA  = DEF_RESET_RA
) (
  input  logic                 clk,
  input  logic                 reset,
  l_commit_stage_if.slave      res,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 mem_req,
  output logic [DATA_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  output logic [DATA_W-1:0]    sp,
  output logic [DATA_W-1:0]    pc,
  output logic [DATA_W-1:0]    ra,
  output logic                 retire
`ifdef L_COMMIT_PERF_EN
  ,
  output logic [31:0]          retire_count,
  output logic [31:0]          stall_count
`endif
);

  commit_state_t        state;
  logic [RF_ADDR_W-1:0] h_rd;
  logic [DATA_W-1:0]    h_alu;
  logic [DATA_W-1:0]    h_sp;
  logic [DATA_W-1:0]    h_pc;
  logic [DATA_W-1:0]    h_ra;
  logic                 h_rw;
  logic                 h_sw;
  logic                 h_pw;
  logic                 h_raw;
  logic                 h_mw;
  logic                 capture;
  logic                 store_done;
  logic                 do_retire;

  assign res.in_ready = (state == IDLE);
  assign capture      = res.in_valid && res.in_ready;
  // Non-store instructions retire from COMMIT directly; stores wait for ack.
  assign do_retire    = (state != IDLE) && (!h_mw || store_done);

  l_commit_store_port #(
    .DATA_W (DATA_W)
  ) u_store (
    .clk        (clk),
    .reset      (reset),
    .start      (capture && res.memory_write),
    .store_addr (res.mem_addr_in),
    .store_data (res.mem_data_in),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .done       (store_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rf_we    <= 1'b0;
      retire   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pc       <= RESET_PC;
      sp       <= RESET_SP;
      ra       <= RESET_RA;
      h_rd     <= '0;
      h_alu    <= '0;
      h_sp     <= '0;
      h_pc     <= '0;
      h_ra     <= '0;
      h_rw     <= 1'b0;
      h_sw     <= 1'b0;
      h_pw     <= 1'b0;
      h_raw    <= 1'b0;
      h_mw     <= 1'b0;
    end else begin
      rf_we  <= 1'b0;
      retire <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            h_rd  <= RF_ADDR_W'(res.instruction[RD_MSB:RD_LSB]);
            h_alu <= res.alu_out;
            h_sp  <= res.sp_in;
            h_pc  <= res.pc_in;
            h_ra  <= res.ra_in;
            h_rw  <= res.register_write;
            h_sw  <= res.sp_write;
            h_pw  <= res.pc_write;
            h_raw <= res.ra_write;
            h_mw  <= res.memory_write;
            state <= COMMIT;
          end
        end
        COMMIT:   state <= do_retire ? IDLE : MEM_WAIT;
        MEM_WAIT: if (do_retire) state <= IDLE;
        default:  state <= IDLE;
      endcase
      if (do_retire) begin
        rf_we    <= h_rw;
        rf_waddr <= h_rd;
        rf_wdata <= h_alu;
        sp       <= h_sw  ? h_sp : sp;
        ra       <= h_raw ? h_ra : ra;
        pc       <= h_pw  ? h_pc : pc + DATA_W'(1);
        retire   <= 1'b1;
      end
    end
  end

`ifdef L_COMMIT_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count <= '0;
      stall_count  <= '0;
    end else begin
      if (do_retire && retire_count != '1)
        retire_count <= retire_count + 32'd1;
      if (state == MEM_WAIT && stall_count != '1)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l_commit_stage.sv
// Scoreboard bench for l_commit_stage: directed plus random instructions,
// random store-ack delays and stray acks, and a reset during MEM_WAIT.
module tb_l_commit_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] sp;
  logic [15:0] pc;
  logic [15:0] ra;
  logic        retire;
`ifdef L_COMMIT_PERF_EN
  logic [31:0] retire_count;
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  l_commit_stage_if #(.DATA_W(16)) res ();

  l_commit_stage #(
    .DATA_W    (16),
    .RF_ADDR_W (3),
    .RESET_PC  (16'h0000),
    .RESET_SP  (16'hFFFF),
    .RESET_RA  (16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .res       (res.slave),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .sp        (sp),
    .pc        (pc),
    .ra        (ra),
    .retire    (retire)
`ifdef L_COMMIT_PERF_EN
    ,
    .retire_count (retire_count),
    .stall_count  (stall_count)
`endif
  );

  typedef struct {
    logic        rf_we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] pc;
    logic [15:0] sp;
    logic [15:0] ra;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int unsigned len;
  } st_t;

  exp_t        exp_q[$];
  st_t         st_q[$];
  int unsigned ack_q[$];

  logic [15:0] m_pc;
  logic [15:0] m_sp;
  logic [15:0] m_ra;
  int unsigned m_retires = 0;
  int unsigned m_stalls  = 0;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  bit          ack_en = 1'b1;
  int unsigned ack_cnt = 0;
  bit          skip_store = 1'b0;
  bit          prev_req = 1'b0;
  int unsigned req_len = 0;
  exp_t        mon_e;
  st_t         mon_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: ack after the queued delay; random noise while idle.
  always @(negedge clk) begin
    if (!ack_en) begin
      mem_ack = 1'b0;
    end else if (mem_req === 1'b1) begin
      if (ack_q.size() > 0 && ack_cnt >= ack_q[0]) begin
        mem_ack = 1'b1;
        void'(ack_q.pop_front());
        ack_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        ack_cnt++;
      end
    end else begin
      mem_ack = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard whenever the DUT retires or stores.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (retire) begin
        if (exp_q.size() == 0) begin
          chk("retire_unexpected", 32'(retire), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rf_we",        32'(rf_we),    32'(mon_e.rf_we));
          chk("rf_waddr",     32'(rf_waddr), 32'(mon_e.waddr));
          chk("rf_wdata",     32'(rf_wdata), 32'(mon_e.wdata));
          chk("pc",           32'(pc),       32'(mon_e.pc));
          chk("sp",           32'(sp),       32'(mon_e.sp));
          chk("ra",           32'(ra),       32'(mon_e.ra));
          chk("retire_cycle", cyc,           mon_e.cyc);
        end
      end else begin
        chk("rf_we_no_retire", 32'(rf_we), 32'd0);
      end
      if (!skip_store) begin
        if (mem_req) begin
          chk("in_ready_busy", 32'(res.in_ready), 32'd0);
          if (st_q.size() == 0) begin
            chk("mem_req_unexpected", 32'(mem_req), 32'd0);
          end else begin
            chk("mem_addr",  32'(mem_addr),  32'(st_q[0].addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(st_q[0].data));
          end
          req_len++;
        end else if (prev_req) begin
          if (st_q.size() > 0) begin
            mon_s = st_q.pop_front();
            chk("mem_req_len", req_len, mon_s.len);
          end
          req_len = 0;
        end
      end
      prev_req = mem_req;
    end
  end

  task automatic set_payload(input logic [15:0] instr, input logic [15:0] alu,
                             input logic [15:0] spi, input logic [15:0] pci,
                             input logic [15:0] rai, input logic [15:0] md,
                             input logic [15:0] ma, input logic [4:0] strobes);
    res.instruction    = instr;
    res.alu_out        = alu;
    res.sp_in          = spi;
    res.pc_in          = pci;
    res.ra_in          = rai;
    res.mem_data_in    = md;
    res.mem_addr_in    = ma;
    res.register_write = strobes[4];
    res.sp_write       = strobes[3];
    res.pc_write       = strobes[2];
    res.ra_write       = strobes[1];
    res.memory_write   = strobes[0];
  endtask

  // strobes = {register_write, sp_write, pc_write, ra_write, memory_write}
  task automatic issue(input logic [15:0] instr, input logic [15:0] alu,
                       input logic [15:0] spi, input logic [15:0] pci,
                       input logic [15:0] rai, input logic [15:0] md,
                       input logic [15:0] ma, input logic [4:0] strobes,
                       input int unsigned dly, input bit track);
    int unsigned waitc = 0;
    exp_t e;
    set_payload(instr, alu, spi, pci, rai, md, ma, strobes);
    res.in_valid = 1'b1;
    while (res.in_ready !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (res.in_ready !== 1'b1) begin
      chk("accept_timeout", 32'(res.in_ready), 32'd1);
      res.in_valid = 1'b0;
      return;
    end
    if (track) begin
      m_sp = strobes[3] ? spi : m_sp;
      m_ra = strobes[1] ? rai : m_ra;
      m_pc = strobes[2] ? pci : m_pc + 16'd1;
      e.rf_we = strobes[4];
      e.waddr = instr[2:0];
      e.wdata = alu;
      e.pc    = m_pc;
      e.sp    = m_sp;
      e.ra    = m_ra;
      e.cyc   = cyc + 2 + (strobes[0] ? dly : 0);
      exp_q.push_back(e);
      if (strobes[0]) begin
        st_q.push_back('{addr: ma, data: md, len: dly + 1});
        ack_q.push_back(dly);
        m_stalls += dly;
      end
      m_retires++;
    end
    @(negedge clk);
    res.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    res.in_valid = 1'b0;
    set_payload('0, '0, '0, '0, '0, '0, '0, 5'b0);
    m_pc = 16'h0000;
    m_sp = 16'hFFFF;
    m_ra = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_in_ready",  32'(res.in_ready), 32'd1);
    chk("rst_rf_we",     32'(rf_we),        32'd0);
    chk("rst_retire",    32'(retire),       32'd0);
    chk("rst_mem_req",   32'(mem_req),      32'd0);
    chk("rst_rf_waddr",  32'(rf_waddr),     32'd0);
    chk("rst_rf_wdata",  32'(rf_wdata),     32'd0);
    chk("rst_mem_addr",  32'(mem_addr),     32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata),    32'd0);
    chk("rst_pc",        32'(pc),           32'h0000);
    chk("rst_sp",        32'(sp),           32'hFFFF);
    chk("rst_ra",        32'(ra),           32'h0000);
`ifdef L_COMMIT_PERF_EN
    chk("rst_retire_count", retire_count, 32'd0);
    chk("rst_stall_count",  stall_count,  32'd0);
`endif

    // Directed: set pc, ADD, branches, wrap, stores, JUMP-style commit.
    issue(16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 5'b00100, 0, 1);
    issue(16'h0003, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b10000, 0, 1);
    issue(16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 5'b00100, 0, 1);
    issue(16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 5'b00100, 0, 1);
    issue(16'h0005, 16'h7777, 16'h1111, 16'h2222, 16'h3333, 16'h0000, 16'h0000, 5'b00000, 0, 1);
    issue(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h8000, 5'b00001, 3, 1);
    issue(16'h0002, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE, 16'h4000, 5'b10001, 0, 1);
    issue(16'h0007, 16'h5A5A, 16'h0F00, 16'h0300, 16'h0123, 16'hD00D, 16'h9000, 5'b11111, 2, 1);
    drain();

    for (int i = 0; i < 150; i++) begin
      logic [4:0] stb;
      stb    = 5'($urandom);
      stb[0] = ($urandom_range(0, 2) == 0);
      issue(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), stb, $urandom_range(0, 3), 1);
      repeat ($urandom_range(0, 2)) begin
        set_payload(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom), 5'($urandom));
        @(negedge clk);
      end
    end
    drain();
`ifdef L_COMMIT_PERF_EN
    chk("retire_count", retire_count, m_retires);
    chk("stall_count",  stall_count,  m_stalls);
`endif

    // Reset while a store sits in MEM_WAIT: nothing retires, state restarts.
    ack_en     = 1'b0;
    skip_store = 1'b1;
    @(negedge clk);
    issue(16'h0004, 16'h4444, 16'h0ABC, 16'h0DEF, 16'h0999, 16'h1357, 16'h2468, 5'b11111, 0, 0);
    @(negedge clk);
    chk("mw_mem_req",  32'(mem_req),      32'd1);
    chk("mw_in_ready", 32'(res.in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mw_mem_req",  32'(mem_req),      32'd0);
    chk("rst_mw_retire",   32'(retire),       32'd0);
    chk("rst_mw_rf_we",    32'(rf_we),        32'd0);
    chk("rst_mw_pc",       32'(pc),           32'h0000);
    chk("rst_mw_sp",       32'(sp),           32'hFFFF);
    chk("rst_mw_ra",       32'(ra),           32'h0000);
    chk("rst_mw_in_ready", 32'(res.in_ready), 32'd1);
`ifdef L_COMMIT_PERF_EN
    chk("rst_mw_retire_count", retire_count, 32'd0);
    chk("rst_mw_stall_count",  stall_count,  32'd0);
    m_retires = 0;
    m_stalls  = 0;
`endif
    m_pc = 16'h0000;
    m_sp = 16'hFFFF;
    m_ra = 16'h0000;
    ack_q.delete();
    ack_cnt = 0;
    repeat (2) @(negedge clk);
    ack_en     = 1'b1;
    skip_store = 1'b0;
    prev_req   = 1'b0;
    req_len    = 0;
    @(negedge clk);

    issue(16'h0006, 16'h0606, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b10000, 0, 1);
    issue(16'h0001, 16'h0101, 16'h0000, 16'h0000, 16'h0000, 16'hF00D, 16'h0042, 5'b10001, 2, 1);
    issue(16'h0002, 16'h0202, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b01000, 0, 1);
    issue(16'h0003, 16'h0303, 16'h0000, 16'h0000, 16'h5555, 16'h0000, 16'h0000, 5'b00010, 0, 1);
    issue(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 0, 1);
    drain();
`ifdef L_COMMIT_PERF_EN
    chk("retire_count_5", retire_count, m_retires);
    chk("stall_count_2",  stall_count,  m_stalls);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
